jtag_master_shifter: RTL and testbench



---
 rtl/jtag_master_shifter_if.sv | 23 ++
 rtl/jtag_master_shifter.sv | 189 ++++++++++++++++++
 tb/tb_jtag_master_shifter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_master_shifter_if.sv
// Command/response bundle between a bus-side client and the JTAG master shifter.
interface jtag_master_shifter_if #(
  parameter int MAX_LEN = 64
) ();
  logic               start_i;
  logic               reset_tap_i;
  logic               is_ir_i;
  logic [6:0]         len_i;
  logic [MAX_LEN-1:0] data_i;
  logic               busy_o;
  logic               done_o;
  logic [MAX_LEN-1:0] data_o;

  modport master (
    output start_i, reset_tap_i, is_ir_i, len_i, data_i,
    input  busy_o, done_o, data_o
  );

  modport slave (
    input  start_i, reset_tap_i, is_ir_i, len_i, data_i,
    output busy_o, done_o, data_o
  );
endinterface

// File: rtl/jtag_master_shifter.sv
// JTAG initiator: walks the TAP from Run-Test/Idle through an IR/DR scan (or a
// TAP reset) and back, driving TCK/TMS/TDI and capturing TDO into data_o.
module jtag_master_shifter #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jtag_master_shifter_if.slave bus,
  output logic                 jtag_clk_o,
  output logic                 jtag_tms_o,
  output logic                 jtag_tdi_o,
  input  logic                 jtag_tdo_i
);
  localparam int            CW      = $clog2(2 * CLK_DIV);
  localparam int            IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] RISE_AT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FALL_AT = CW'(2 * CLK_DIV - 1);
  localparam logic [6:0]    LEN_MAX = 7'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET_SEQ, S_PRE, S_SHIFT, S_POST, S_DONE
  } state_t;

  // TMS value for TCK number b inside a walking state.
  function automatic logic tms_of(state_t s, logic [6:0] b, logic [6:0] len, logic ir);
    case (s)
      S_RESET_SEQ: tms_of = (b < 7'd5);
      S_PRE:       tms_of = ir ? (b < 7'd2) : (b == 7'd0);
      S_SHIFT:     tms_of = (b == len - 7'd1);
      S_POST:      tms_of = (b == 7'd0);
      default:     tms_of = 1'b0;
    endcase
  endfunction

  // Index of the last TCK spent in a walking state.
  function automatic logic [6:0] last_of(state_t s, logic [6:0] len, logic ir);
    case (s)
      S_RESET_SEQ: last_of = 7'd5;
      S_PRE:       last_of = ir ? 7'd3 : 7'd2;
      S_SHIFT:     last_of = len - 7'd1;
      default:     last_of = 7'd1;
    endcase
  endfunction

  function automatic state_t follow_of(state_t s);
    case (s)
      S_PRE:   follow_of = S_SHIFT;
      S_SHIFT: follow_of = S_POST;
      default: follow_of = S_DONE;
    endcase
  endfunction

  state_t             r_state, w_state, w_nstate;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic [6:0]         r_bit, w_bit, w_nbit;
  logic               r_arm, w_arm;     // first clk of a command: load first TMS
  logic               r_auto, w_auto;   // post-reset TAP reset, no done pulse
  logic [6:0]         r_len, w_len;
  logic               r_is_ir, w_is_ir;
  logic [MAX_LEN-1:0] r_data, w_data;
  logic [MAX_LEN-1:0] r_cap, w_cap;
  logic               r_tck, w_tck;
  logic               r_tms, w_tms;
  logic               r_tdi, w_tdi;
  logic               r_busy, w_busy;
  logic               r_done, w_done;

  assign jtag_clk_o  = r_tck;
  assign jtag_tms_o  = r_tms;
  assign jtag_tdi_o  = r_tdi;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;
  assign bus.data_o  = r_cap;

  // Register every state bit and pin; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_arm   <= 1'b0;
      r_auto  <= 1'b1;
      r_len   <= '0;
      r_is_ir <= 1'b0;
      r_data  <= '0;
      r_cap   <= '0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_arm   <= w_arm;
      r_auto  <= w_auto;
      r_len   <= w_len;
      r_is_ir <= w_is_ir;
      r_data  <= w_data;
      r_cap   <= w_cap;
      r_tck   <= w_tck;
      r_tms   <= w_tms;
      r_tdi   <= w_tdi;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  // Next state: accept commands, pace TCK, step through the TMS walk.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_bit    = r_bit;
    w_arm    = 1'b0;
    w_auto   = r_auto;
    w_len    = r_len;
    w_is_ir  = r_is_ir;
    w_data   = r_data;
    w_cap    = r_cap;
    w_tck    = r_tck;
    w_tms    = r_tms;
    w_tdi    = r_tdi;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_nstate = r_state;
    w_nbit   = r_bit;
    case (r_state)
      S_IDLE: begin
        if (r_auto) begin
          w_state = S_RESET_SEQ;
          w_arm   = 1'b1;
          w_busy  = 1'b1;
          w_cap   = '0;
        end else if (bus.start_i && !r_done) begin
          // The done clk still has busy low, but a start there is dropped.
          w_state = bus.reset_tap_i ? S_RESET_SEQ : S_PRE;
          w_arm   = 1'b1;
          w_busy  = 1'b1;
          w_cap   = '0;
          w_len   = (bus.len_i > LEN_MAX) ? LEN_MAX : bus.len_i;
          w_is_ir = bus.is_ir_i;
          w_data  = bus.data_i;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_done  = !r_auto;
        w_auto  = 1'b0;
      end
      default: begin
        if (r_arm) begin
          if (r_state == S_PRE && r_len == 7'd0) begin
            w_state = S_DONE;
          end else begin
            w_cnt = '0;
            w_bit = '0;
            w_tck = 1'b0;
            w_tms = tms_of(r_state, 7'd0, r_len, r_is_ir);
            w_tdi = 1'b0;
          end
        end else if (r_cnt == RISE_AT) begin
          w_tck = 1'b1;
          w_cnt = r_cnt + CW'(1);
          if (r_state == S_SHIFT)
            w_cap[r_bit[IW-1:0]] = jtag_tdo_i;
        end else if (r_cnt == FALL_AT) begin
          w_tck = 1'b0;
          w_cnt = '0;
          if (r_bit == last_of(r_state, r_len, r_is_ir)) begin
            w_nstate = follow_of(r_state);
            w_nbit   = '0;
          end else begin
            w_nbit   = r_bit + 7'd1;
          end
          w_state = w_nstate;
          w_bit   = w_nbit;
          if (w_nstate != S_DONE)
            w_tms = tms_of(w_nstate, w_nbit, r_len, r_is_ir);
          w_tdi = (w_nstate == S_SHIFT) ? r_data[w_nbit[IW-1:0]] : 1'b0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
    endcase
  end
endmodule

// File: tb/tb_jtag_master_shifter.sv
// Randomized bench for jtag_master_shifter with a cycle-level reference model
// derived from the TMS walk tables and TCK timing rules.
module tb_jtag_master_shifter;
  localparam int D  = 2;
  localparam int ML = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic jtck, jtms, jtdi, jtdo;
  logic tdo_loop = 1'b1;
  logic tdo_r = 1'b0;
  bit   tdo_rand = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  jtag_master_shifter_if #(.MAX_LEN(ML)) bus ();

  jtag_master_shifter #(.CLK_DIV(D), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .jtag_clk_o(jtck), .jtag_tms_o(jtms), .jtag_tdi_o(jtdi), .jtag_tdo_i(jtdo)
  );

  assign jtdo = tdo_loop ? jtdi : tdo_r;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (tdo_rand) tdo_r = 1'($urandom_range(1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event cycle=%0d", nm, cyc);
  endtask

  // ---------------- reference model ----------------
  bit          armed = 1'b0;
  bit          m_act = 1'b0, m_init = 1'b0, m_auto = 1'b0;
  int          m_k, m_n, m_pre, m_len;
  bit          m_tms [256];
  bit          m_tdi [256];
  logic        e_tck, e_tms, e_tdi, e_busy, e_done;
  logic [63:0] e_data;

  always @(posedge clk) begin : mdl
    int  p, j, L;
    bit  was_done;
    if (!rst_n) begin
      e_tck = 0; e_tms = 1; e_tdi = 0; e_busy = 0; e_done = 0; e_data = '0;
      m_act = 0; m_init = 1; armed = 1;
    end else if (m_act) begin
      m_k++;
      if (m_k <= 2 * D * m_n) begin
        p = (m_k - 1) / (2 * D);
        j = (m_k - 1) % (2 * D);
        e_tck = (j >= D);
        e_tms = m_tms[p];
        e_tdi = m_tdi[p];
        if (j == D && p >= m_pre && p < m_pre + m_len)
          e_data[p - m_pre] = tdo_loop ? m_tdi[p] : tdo_r;
      end else if (m_k == 2 * D * m_n + 1) begin
        e_tck = 0;
        e_tdi = 0;
      end else begin
        e_busy = 0;
        e_done = !m_auto;
        m_act  = 0;
      end
    end else begin
      was_done = e_done;
      e_done = 0;
      if (m_init || (bus.start_i && !was_done)) begin
        m_auto = m_init;
        m_act = 1; m_k = 0; e_busy = 1; e_data = '0;
        m_pre = 0; m_len = 0; m_n = 0;
        L = (int'(bus.len_i) > ML) ? ML : int'(bus.len_i);
        if (m_init || bus.reset_tap_i) begin
          for (int i = 0; i < 6; i++) begin m_tms[i] = (i < 5); m_tdi[i] = 0; end
          m_n = 6;
        end else if (L > 0) begin
          m_pre = bus.is_ir_i ? 4 : 3;
          for (int i = 0; i < m_pre; i++) begin
            m_tms[i] = bus.is_ir_i ? (i < 2) : (i == 0);
            m_tdi[i] = 0;
          end
          for (int i = 0; i < L; i++) begin
            m_tms[m_pre + i] = (i == L - 1);
            m_tdi[m_pre + i] = bus.data_i[i];
          end
          m_tms[m_pre + L] = 1; m_tdi[m_pre + L] = 0;
          m_tms[m_pre + L + 1] = 0; m_tdi[m_pre + L + 1] = 0;
          m_len = L;
          m_n = m_pre + L + 2;
        end
        m_init = 0;
      end
    end
  end

  // Compare every DUT output against the model once per clk.
  always @(negedge clk) begin
    if (armed) begin
      chk("tck",    64'(jtck),        64'(e_tck));
      chk("tms",    64'(jtms),        64'(e_tms));
      chk("tdi",    64'(jtdi),        64'(e_tdi));
      chk("busy",   64'(bus.busy_o),  64'(e_busy));
      chk("done",   64'(bus.done_o),  64'(e_done));
      chk("data_o", bus.data_o,       e_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit rt, input bit ir, input int len, input logic [63:0] d,
                       output int acc);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!bus.busy_o && !bus.done_o) begin ok = 1; break; end
    end
    if (!ok) fail_now("ready_wait");
    bus.reset_tap_i = rt; bus.is_ir_i = ir; bus.len_i = 7'(len); bus.data_i = d;
    bus.start_i = 1;
    acc = cyc + 1;
  endtask

  task automatic wait_done(input bit noise, input int acc, output int lat, output int rises,
                           output logic [127:0] tseq, output logic [63:0] dout);
    logic pt;
    pt = jtck; rises = 0; tseq = '0; lat = -1; dout = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start_i = 0;
      if (jtck && !pt) begin rises++; tseq = {tseq[126:0], jtms}; end
      pt = jtck;
      if (bus.done_o) begin lat = cyc - acc; dout = bus.data_o; break; end
      if (noise && $urandom_range(3) == 0) begin
        bus.start_i = 1; bus.reset_tap_i = 1'($urandom_range(1));
        bus.is_ir_i = 1'($urandom_range(1)); bus.len_i = 7'($urandom_range(127));
        bus.data_i = {$urandom, $urandom};
      end
    end
    if (lat < 0) fail_now("done_wait");
  endtask

  // Watch an auto TAP reset: busy cycles, TCK rises, TMS pattern, done pulses.
  task automatic watch_init(output int bcyc, output int rises, output int dn,
                            output logic [127:0] tseq);
    logic pt;
    bit   ok;
    pt = jtck; bcyc = 0; rises = 0; dn = 0; tseq = '0; ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.busy_o) bcyc++;
      if (bus.done_o) dn++;
      if (jtck && !pt) begin rises++; tseq = {tseq[126:0], jtms}; end
      pt = jtck;
      if (!bus.busy_o && bcyc > 0) begin ok = 1; break; end
    end
    if (!ok) fail_now("init_wait");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int acc, lat, rises, bcyc, dn;
    logic [127:0] tseq;
    logic [63:0]  dout, d;
    bus.start_i = 0; bus.reset_tap_i = 0; bus.is_ir_i = 0; bus.len_i = '0; bus.data_i = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy_o), 64'(0));
    chk("rst_tms",  64'(jtms),       64'(1));
    rst_n = 1;
    watch_init(bcyc, rises, dn, tseq);
    chk("init_busy_cycles", 64'(bcyc), 64'(26));
    chk("init_tck_rises",   64'(rises), 64'(6));
    chk("init_tms_seq",     64'(tseq[5:0]), 64'h3E);
    chk("init_no_done",     64'(dn), 64'(0));

    // DR len=8 loopback
    tdo_loop = 1;
    issue(0, 0, 8, 64'hA5, acc);
    wait_done(0, acc, lat, rises, tseq, dout);
    chk("dr8_latency", 64'(lat), 64'(54));
    chk("dr8_rises",   64'(rises), 64'(13));
    chk("dr8_tms_seq", 64'(tseq[12:0]), 64'h1006);
    chk("dr8_data",    dout, 64'hA5);

    // start in the done clk must be dropped
    bus.start_i = 1; bus.reset_tap_i = 0; bus.len_i = 7'd4;
    @(negedge clk);
    bus.start_i = 0;
    chk("start_at_done_ignored", 64'(bus.busy_o), 64'(0));

    // IR len=5, TDO held high
    tdo_loop = 0; tdo_r = 1;
    issue(0, 1, 5, 64'h11, acc);
    wait_done(0, acc, lat, rises, tseq, dout);
    chk("ir5_latency", 64'(lat), 64'(46));
    chk("ir5_rises",   64'(rises), 64'(11));
    chk("ir5_tms_seq", 64'(tseq[10:0]), 64'h606);
    chk("ir5_data",    dout, 64'h1F);

    // DR len=64 loopback with start noise while busy
    tdo_loop = 1;
    issue(0, 0, 64, 64'hDEADBEEF_01234567, acc);
    wait_done(1, acc, lat, rises, tseq, dout);
    chk("dr64_latency", 64'(lat), 64'(278));
    chk("dr64_data",    dout, 64'hDEADBEEF_01234567);

    // len=0: no TCK, done two clks after accept
    issue(0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, acc);
    wait_done(0, acc, lat, rises, tseq, dout);
    chk("len0_latency", 64'(lat), 64'(2));
    chk("len0_rises",   64'(rises), 64'(0));
    chk("len0_data",    dout, 64'h0);

    // len>MAX_LEN clamps to MAX_LEN
    issue(0, 0, 100, 64'h0123_4567_89AB_CDEF, acc);
    wait_done(0, acc, lat, rises, tseq, dout);
    chk("clamp_latency", 64'(lat), 64'(278));
    chk("clamp_data",    dout, 64'h0123_4567_89AB_CDEF);

    // reset_tap command with IR also set: reset wins
    issue(1, 1, 9, 64'h1FF, acc);
    wait_done(0, acc, lat, rises, tseq, dout);
    chk("rtap_latency", 64'(lat), 64'(26));
    chk("rtap_tms_seq", 64'(tseq[5:0]), 64'h3E);

    // reset in the middle of SHIFT
    issue(0, 0, 20, {$urandom, $urandom}, acc);
    @(negedge clk);
    bus.start_i = 0;
    repeat (30) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_busy", 64'(bus.busy_o), 64'(0));
    chk("midrst_tck",  64'(jtck),       64'(0));
    chk("midrst_tms",  64'(jtms),       64'(1));
    chk("midrst_done", 64'(bus.done_o), 64'(0));
    chk("midrst_data", bus.data_o,      64'h0);
    rst_n = 1;
    watch_init(bcyc, rises, dn, tseq);
    chk("midrst_reinit_busy", 64'(bcyc), 64'(26));
    chk("midrst_reinit_done", 64'(dn),   64'(0));

    // random commands against the model
    for (int n = 0; n < 40; n++) begin
      tdo_loop = 1'($urandom_range(1));
      tdo_rand = !tdo_loop;
      d = {$urandom, $urandom};
      issue(($urandom_range(7) == 0), 1'($urandom_range(1)), $urandom_range(71), d, acc);
      wait_done(1'($urandom_range(1)), acc, lat, rises, tseq, dout);
    end
    tdo_rand = 0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
